// File: rtl/mips_cpu_pkg.sv
// Shared CPU definitions: data-memory SRAM controller state encoding and default address width.
package mips_cpu_pkg;

  localparam int DM_SRAM_ADDR_W = 20;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4
  } dm_sram_state_enum;

endpackage

// File: rtl/dm_sram_rdbuf.sv
// One-entry load buffer for dm_sram_ctrl: lookup by word address, refill on SRAM loads,
// invalidate on any store to the buffered word.
module dm_sram_rdbuf #(
  parameter int ADDR_W = 20
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] lookup_addr_i,
  output logic              hit_o,
  output logic [31:0]       data_o,
  input  logic              refill_i,
  input  logic [ADDR_W-1:0] refill_addr_i,
  input  logic [31:0]       refill_data_i,
  input  logic              inv_i,
  input  logic [ADDR_W-1:0] inv_addr_i
);

  logic              valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;

  // Refill happens in ACCESS and invalidation at request acceptance, so they never coincide.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (refill_i) begin
      valid_q <= 1'b1;
      addr_q  <= refill_addr_i;
      data_q  <= refill_data_i;
    end else if (inv_i && (inv_addr_i == addr_q)) begin
      valid_q <= 1'b0;
    end
  end

  assign hit_o  = valid_q && (lookup_addr_i == addr_q);
  assign data_o = data_q;

endmodule

// File: rtl/dm_sram_ctrl.sv
// Data-memory responder running multi-cycle accesses on an asynchronous 32-bit SRAM.
// Optional one-entry load buffer enabled by defining DM_SRAM_FASTREAD_EN.
module dm_sram_ctrl
  import mips_cpu_pkg::*;
#(
  parameter int ADDR_W      = DM_SRAM_ADDR_W,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst,
  input  logic              dmce,
  input  logic              dmwe,
  input  logic [3:0]        dmbe,
  input  logic [31:0]       dmaddr,
  input  logic [31:0]       dmdin,
  output logic [31:0]       dmdout,
  output logic              dm_ack,
  output logic              dm_stall,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_din,
  output logic              sram_dq_oe,
  input  logic [31:0]       sram_dout,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [3:0]        sram_be_n,
  output dm_sram_state_enum dbg_state_o
);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("dm_sram_ctrl: WAIT_CYCLES must be in 1..15");
  end

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  // Handshake: the CPU holds dmce (and its fields) until dm_ack; dm_ack is a one-cycle
  // pulse in DONE, and the request fields are latched when IDLE sees dmce.
  dm_sram_state_enum state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       din_q, dout_q;
  logic [3:0]        be_q;
  logic              we_q;

  logic [ADDR_W-1:0] req_addr;
  logic              accept, last_access, buf_hit;
  logic [31:0]       buf_data;
  logic              unused_addr_bits;

  assign req_addr         = dmaddr[ADDR_W+1:2];
  assign unused_addr_bits = ^{dmaddr[31:ADDR_W+2], dmaddr[1:0]};
  assign accept           = (state_q == IDLE) && dmce;
  assign last_access      = (state_q == ACCESS) && (cnt_q == LAST_CNT);

`ifdef DM_SRAM_FASTREAD_EN
  dm_sram_rdbuf #(.ADDR_W(ADDR_W)) u_rdbuf (
    .clk_i         (cpu_clk_50M),
    .rst_i         (cpu_rst),
    .lookup_addr_i (req_addr),
    .hit_o         (buf_hit),
    .data_o        (buf_data),
    .refill_i      (last_access && !we_q),
    .refill_addr_i (addr_q),
    .refill_data_i (sram_dout),
    .inv_i         (accept && dmwe),
    .inv_addr_i    (req_addr)
  );
`else
  assign buf_hit  = 1'b0;
  assign buf_data = '0;
`endif

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q <= req_addr;
        din_q  <= dmdin;
        be_q   <= dmbe;
        we_q   <= dmwe;
      end
      if (last_access && !we_q) begin
        dout_q <= sram_dout;
      end else if (accept && !dmwe && buf_hit) begin
        dout_q <= buf_data;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (dmce) begin
          // Zero-enable stores and buffered loads skip the SRAM cycle entirely.
          if ((dmwe && (dmbe == 4'b0000)) || (!dmwe && buf_hit)) state_d = DONE;
          else                                                   state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = '0;
      end
      ACCESS: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = we_q ? HOLD : DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HOLD:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sram_ce_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_be_n  = 4'b1111;
    sram_dq_oe = 1'b0;
    dm_ack     = 1'b0;
    unique case (state_q)
      SETUP, ACCESS, HOLD: begin
        sram_ce_n = 1'b0;
        if (we_q) begin
          sram_dq_oe = 1'b1;
          sram_be_n  = ~be_q;
          sram_we_n  = (state_q != ACCESS);
        end else begin
          sram_oe_n = 1'b0;
          sram_be_n = 4'b0000;
        end
      end
      DONE:    dm_ack = 1'b1;
      default: ;
    endcase
  end

  assign sram_addr   = addr_q;
  assign sram_din    = din_q;
  assign dmdout      = dout_q;
  assign dm_stall    = dmce & ~dm_ack & ~cpu_rst;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dm_sram_ctrl.sv
// Bench for dm_sram_ctrl: pin-level SRAM model, word-level reference memory and scoreboard.
module tb_dm_sram_ctrl;
  import mips_cpu_pkg::*;

  localparam int W  = 2;
  localparam int AW = 20;

  logic          clk = 1'b0;
  logic          rst, dmce, dmwe;
  logic [3:0]    dmbe;
  logic [31:0]   dmaddr, dmdin, dmdout;
  logic          dm_ack, dm_stall;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_din, sram_dout;
  logic          sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic [3:0]    sram_be_n;
  dm_sram_state_enum dbg_state;

  dm_sram_ctrl #(.ADDR_W(AW), .WAIT_CYCLES(W)) dut (
    .cpu_clk_50M (clk),       .cpu_rst    (rst),        .dmce      (dmce),
    .dmwe        (dmwe),      .dmbe       (dmbe),       .dmaddr    (dmaddr),
    .dmdin       (dmdin),     .dmdout     (dmdout),     .dm_ack    (dm_ack),
    .dm_stall    (dm_stall),  .sram_addr  (sram_addr),  .sram_din  (sram_din),
    .sram_dq_oe  (sram_dq_oe),.sram_dout  (sram_dout),  .sram_ce_n (sram_ce_n),
    .sram_oe_n   (sram_oe_n), .sram_we_n  (sram_we_n),  .sram_be_n (sram_be_n),
    .dbg_state_o (dbg_state)
  );

  // clock / cycle counter
  always #10 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Asynchronous SRAM model: a write commits when WE rises with CE still low.
  logic [31:0] sram_mem [32];
  logic        wr_pend = 1'b0;
  assign sram_dout = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr[4:0]] : 32'hBAD0BAD0;

  always @(negedge clk) begin
    if (sram_ce_n === 1'b0 && sram_we_n === 1'b0) begin
      wr_pend = 1'b1;
    end else begin
      if (wr_pend && sram_ce_n === 1'b0)
        for (int i = 0; i < 4; i++)
          if (!sram_be_n[i]) sram_mem[sram_addr[4:0]][8*i +: 8] = sram_din[8*i +: 8];
      wr_pend = 1'b0;
    end
  end

  // Reference model: word memory plus one-entry buffer tag.
  logic [31:0] ref_mem [32];
  bit          buf_v = 1'b0;
  logic [4:0]  buf_w = '0;

  // Scoreboard entries: {is_load, ack_cycle[15:0], load_data[31:0]}
  logic [48:0] exp_q [$];

  always @(negedge clk) begin
    logic [48:0] e;
    if (dm_ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ack: got dm_ack at cycle %0d, required none", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("ack_cycle", cyc, {16'd0, e[47:32]});
        if (e[48]) chk("load_data", dmdout, e[31:0]);
      end
    end
    if (sram_ce_n === 1'b0) begin
      checks++;
      if ((sram_we_n === 1'b0 && (sram_oe_n !== 1'b1 || sram_dq_oe !== 1'b1)) ||
          (sram_oe_n === 1'b0 && (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0)) ||
          (sram_addr >= 32)) begin
        errors++;
        $display("FAIL pin_protocol: got oe_n=%b we_n=%b dq_oe=%b addr=0x%05h, required exclusive strobes",
                 sram_oe_n, sram_we_n, sram_dq_oe, sram_addr);
      end
    end else if (sram_we_n !== 1'b1 || sram_oe_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
      checks++; errors++;
      $display("FAIL pin_idle: got oe_n=%b we_n=%b dq_oe=%b with ce_n high, required 1/1/0",
               sram_oe_n, sram_we_n, sram_dq_oe);
    end
  end

  // driver
  logic        tr_ce [64], tr_oe [64], tr_we [64], tr_st [64];
  logic [31:0] tr_addr [64];
  int          k_ack;

  task automatic run_req(input logic we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] data, input bit drop);
    int          lat;
    logic [4:0]  word;
    logic [31:0] ed;
    @(posedge clk); #1;
    dmce = 1'b1; dmwe = we; dmbe = be; dmaddr = addr; dmdin = data;
    word = addr[6:2];
    ed   = ref_mem[word];
    if (we) begin
      lat = (be == 4'b0000) ? 1 : W + 3;
      for (int i = 0; i < 4; i++) if (be[i]) ref_mem[word][8*i +: 8] = data[8*i +: 8];
      if (buf_v && buf_w == word) buf_v = 1'b0;
    end else begin
      lat = W + 2;
`ifdef DM_SRAM_FASTREAD_EN
      if (buf_v && buf_w == word) lat = 1;
      else begin buf_v = 1'b1; buf_w = word; end
`endif
    end
    exp_q.push_back({~we, 16'(cyc + lat), ed});
    k_ack = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      tr_ce[k] = sram_ce_n; tr_oe[k] = sram_oe_n; tr_we[k] = sram_we_n;
      tr_st[k] = dm_stall;  tr_addr[k] = 32'(sram_addr);
      if (dm_ack === 1'b1) begin k_ack = k; break; end
      @(posedge clk); #1;
      if (k == 0) begin dmaddr = $urandom; dmdin = $urandom; dmbe = 4'($urandom); end
      if (drop && k == 1) dmce = 1'b0;
    end
    if (k_ack < 0) begin
      checks++; errors++;
      $display("FAIL ack_timeout: got no dm_ack within 40 cycles, required one");
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    dmce = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ce_n"},  sram_ce_n,  32'd1);
    chk({tag, "_oe_n"},  sram_oe_n,  32'd1);
    chk({tag, "_we_n"},  sram_we_n,  32'd1);
    chk({tag, "_be_n"},  sram_be_n,  32'hF);
    chk({tag, "_dq_oe"}, sram_dq_oe, 32'd0);
    chk({tag, "_addr"},  sram_addr,  32'd0);
    chk({tag, "_din"},   sram_din,   32'd0);
    chk({tag, "_dmdout"},dmdout,     32'd0);
    chk({tag, "_ack"},   dm_ack,     32'd0);
    chk({tag, "_stall"}, dm_stall,   32'd0);
    chk({tag, "_state"}, dbg_state,  IDLE);
  endtask

  initial begin
    int a1, a2;
    logic [4:0] word;
    bit   drop;
    for (int i = 0; i < 32; i++) begin
      sram_mem[i] = $urandom;
      ref_mem[i]  = sram_mem[i];
    end
    rst = 1'b1; dmce = 1'b1; dmwe = 1'b0; dmbe = '0; dmaddr = '0; dmdin = '0;
    repeat (3) @(posedge clk);
    #1 check_reset("reset");
    dmce = 1'b0; rst = 1'b0;
    repeat (2) @(posedge clk);

    // 1: load of word 0x10
    sram_mem[16] = 32'hDEADBEEF; ref_mem[16] = 32'hDEADBEEF;
    run_req(1'b0, 4'h0, 32'h40, 32'h0, 1'b0);
    chk("t1_ack_k", k_ack, 32'd4);
    chk("t1_addr", tr_addr[1], 32'h10);
    for (int k = 0; k <= 4; k++) begin
      chk("t1_oe_n", tr_oe[k], (k >= 1 && k <= 3) ? 32'd0 : 32'd1);
      chk("t1_stall", tr_st[k], (k <= 3) ? 32'd1 : 32'd0);
    end
    idle(1);

    // 2: byte-lane store over 0xAAAAAAAA and readback
    run_req(1'b1, 4'hF, 32'h48, 32'hAAAAAAAA, 1'b0);
    idle(0);
    run_req(1'b1, 4'b0110, 32'h48, 32'h11223344, 1'b0);
    chk("t2_ack_k", k_ack, 32'd5);
    for (int k = 0; k <= 5; k++) chk("t2_we_n", tr_we[k], (k == 2 || k == 3) ? 32'd0 : 32'd1);
    chk("t2_hold_ce_n", tr_ce[4], 32'd0);
    idle(0);
    run_req(1'b0, 4'h0, 32'h48, 32'h0, 1'b0);
    idle(1);

    // 3: zero-enable store leaves memory alone
    run_req(1'b1, 4'h0, 32'h4C, 32'hFFFFFFFF, 1'b0);
    chk("t3_ack_k", k_ack, 32'd1);
    for (int k = 0; k <= 1; k++) begin
      chk("t3_ce_n", tr_ce[k], 32'd1);
      chk("t3_we_n", tr_we[k], 32'd1);
    end
    idle(0);
    run_req(1'b0, 4'h0, 32'h4C, 32'h0, 1'b0);
    idle(1);

    // 4: reset during the strobe of a store
    @(posedge clk); #1;
    dmce = 1'b1; dmwe = 1'b1; dmbe = 4'hF; dmaddr = 32'h50; dmdin = 32'h5555AAAA;
    repeat (2) @(posedge clk);
    #1 chk("t4_we_low", sram_we_n, 32'd0);
    rst = 1'b1;
    #1 chk("t4_stall_rst", dm_stall, 32'd0);
    @(posedge clk);
    #1 check_reset("t4");
    dmce = 1'b0; rst = 1'b0; buf_v = 1'b0;
    run_req(1'b0, 4'h0, 32'h50, 32'h0, 1'b0);
    chk("t4_after_ack_k", k_ack, 32'd4);
    idle(1);

    // 5: load / load / store / load on the same word
    run_req(1'b0, 4'h0, 32'h40, 32'h0, 1'b0);
    idle(0);
    run_req(1'b0, 4'h0, 32'h40, 32'h0, 1'b0);
`ifdef DM_SRAM_FASTREAD_EN
    chk("t5_hit_ack_k", k_ack, 32'd1);
    chk("t5_hit_ce_n0", tr_ce[0], 32'd1);
    chk("t5_hit_ce_n1", tr_ce[1], 32'd1);
`else
    chk("t5_miss_ack_k", k_ack, 32'd4);
`endif
    idle(0);
    run_req(1'b1, 4'hF, 32'h40, 32'hC0FFEE01, 1'b0);
    idle(0);
    run_req(1'b0, 4'h0, 32'h40, 32'h0, 1'b0);
    chk("t5_after_store_ack_k", k_ack, 32'd4);
    idle(1);

    // 6: back-to-back loads with dmce held
    run_req(1'b0, 4'h0, 32'h44, 32'h0, 1'b0);
    a1 = cyc;
    run_req(1'b0, 4'h0, 32'h58, 32'h0, 1'b0);
    a2 = cyc;
    chk("t6_ack_gap", a2 - a1, 32'd5);
    idle(1);

    // random traffic over a few words so the buffer sees hits and invalidations
    for (int n = 0; n < 80; n++) begin
      word = 5'($urandom_range(0, 7));
      drop = ($urandom_range(0, 3) == 0);
      run_req(1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom),
              {10'($urandom), 15'd0, word, 2'($urandom)},
              $urandom, drop);
      if (drop || $urandom_range(0, 1) == 1) idle($urandom_range(0, 3));
    end
    idle(5);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_sram_ctrl.md
# dm_sram_ctrl

Responder for the CPU data-memory port. It accepts single-word load and store requests from the MEM stage and runs multi-cycle accesses on an external asynchronous 32-bit SRAM. It returns load data and a stall to the pipeline. It sits between `stage_mem` and the board SRAM pins, replacing the single-cycle on-chip `dm` when data lives off-chip.

## Interface
Parameters:
- `ADDR_W`, 20: SRAM word-address width.
- `WAIT_CYCLES`, 2: SRAM strobe width in cycles; legal range 1..15.

Ports:
- `cpu_clk_50M`, in, 1: the single clock.
- `cpu_rst`, in, 1: synchronous, active-high reset.
- `dmce`, in, 1: request valid; held by the CPU until `dm_ack`.
- `dmwe`, in, 1: 1 = store, 0 = load.
- `dmbe`, in, 4: store byte enables; bit i selects byte lane [8i+7:8i].
- `dmaddr`, in, 32: byte address; bits [1:0] are ignored.
- `dmdin`, in, 32: store data.
- `dmdout`, out, 32: load data, registered, valid while `dm_ack`=1.
- `dm_ack`, out, 1: one-cycle completion pulse.
- `dm_stall`, out, 1: `dmce & ~dm_ack & ~cpu_rst`, combinational; freezes the pipeline.
- `sram_addr`, out, ADDR_W: word address, equal to `dmaddr[ADDR_W+1:2]`.
- `sram_din`, out, 32: write data to the pad.
- `sram_dq_oe`, out, 1: pad output enable; the top level builds the tristate.
- `sram_dout`, in, 32: read data from the pad.
- `sram_ce_n`, out, 1: chip enable, active low.
- `sram_oe_n`, out, 1: output enable, active low.
- `sram_we_n`, out, 1: write enable, active low.
- `sram_be_n`, out, 4: byte enables, active low.

## Operation
The FSM states are IDLE, SETUP, ACCESS, HOLD and DONE. A wait counter of 4 bits runs in ACCESS.

- **IDLE**
  - A request is accepted when `dmce`=1.
  - On acceptance, the word address, data and byte enables are latched.
  - The next state is SETUP.
  - Exception: a store with `dmbe`=0 goes to DONE directly and does no SRAM cycle.
- **SETUP**, 1 cycle
  - `ce_n`=0 and the address is driven.
  - Load: `oe_n`=0 and `be_n`=0000.
  - Store: `sram_din` is driven, `sram_dq_oe`=1, `be_n`=~dmbe and `we_n`=1.
- **ACCESS**, WAIT_CYCLES cycles
  - Load: `oe_n` is held at 0. `sram_dout` is captured into `dmdout` on the last ACCESS edge. Next state is DONE.
  - Store: `we_n`=0. Next state is HOLD.
- **HOLD**, 1 cycle, store only: `we_n`=1 while address, data and `be_n` are held. This gives data hold after the WE rising edge.
- **DONE**, 1 cycle
  - `dm_ack`=1, and all strobes are deasserted (`ce_n`, `oe_n`, `we_n` = 1; `be_n`=1111; `sram_dq_oe`=0).
  - `dmce` is not sampled in DONE. The next state is always IDLE.
- The latched request fields are used for the whole access; `dmaddr`, `dmdin` and `dmbe` may change after acceptance without effect.
- If `dmce` drops mid-access, the access still completes and `dm_ack` still pulses.

## Timing
Cycle 0 is the IDLE cycle in which `dmce` is first seen.

- **Load:** SETUP at cycle 1, ACCESS at cycles 2..W+1, `dm_ack` and `dmdout` at cycle W+2.
- **Store:** SETUP at cycle 1, `we_n` low at cycles 2..W+1, HOLD at cycle W+2, `dm_ack` at cycle W+3.
- **Zero-enable store:** `dm_ack` at cycle 1.
- **Back-to-back:** the next request is accepted in the IDLE cycle after DONE. Load throughput is W+3 cycles per access.
- **Reset values:**
  - `sram_ce_n`, `sram_oe_n`, `sram_we_n` = 1.
  - `sram_be_n` = 1111.
  - `sram_dq_oe` = 0.
  - `sram_addr`, `sram_din`, `dmdout` = 0.
  - `dm_ack` = 0 and `dm_stall` = 0.
  - State = IDLE, counter = 0.
- **Reset mid-access:** the access is aborted at the next edge. `we_n` returns high immediately, no `dm_ack` is issued, and the CPU reissues the request.
- **WAIT_CYCLES:** values outside 1..15 are an elaboration error.

## Configuration
Macro: `DM_SRAM_FASTREAD_EN`.

- **Defined:** a one-entry read buffer holds {valid, word address, data}.
  - A load whose word address matches a valid entry goes IDLE→DONE. It gets `dm_ack` at cycle 1 with the buffered data and no SRAM cycle.
  - Every SRAM load refills the buffer.
  - Any store to the buffered word clears valid, including a zero-enable store.
  - Reset clears valid.
- **Undefined:** the buffer logic is absent and every load runs the full SRAM cycle.

## Structure
- `mips_cpu_pkg` gains:
  - typedef `dm_sram_state_enum` (IDLE, SETUP, ACCESS, HOLD, DONE);
  - localparam `DM_SRAM_ADDR_W` = 20.
- Sub-module `dm_sram_rdbuf` holds the read buffer: lookup, refill and invalidate. It is instantiated only under `DM_SRAM_FASTREAD_EN`.

## Test plan
All scenarios use W=2.

1. **Load:** SRAM model word 0x00010 = 0xDEADBEEF; load from `dmaddr`=0x40.
   - `sram_addr`=0x10, `oe_n` low for cycles 1..3.
   - `dm_ack` at cycle 4 with `dmdout`=0xDEADBEEF.
   - `dm_stall` high for cycles 0..3.
2. **Byte-lane store:** store `dmbe`=0110, `dmdin`=0x11223344 over a word of 0xAAAAAAAA.
   - `we_n` low exactly at cycles 2..3; HOLD at cycle 4; `dm_ack` at cycle 5.
   - A readback returns 0xAA2233AA.
3. **Zero-enable store:** store with `dmbe`=0000.
   - `dm_ack` at cycle 1.
   - `ce_n` and `we_n` never go low.
   - The memory is unchanged.
4. **Reset mid-store:** assert `cpu_rst` at cycle 2.
   - `we_n`=1 and `ce_n`=1 from the next edge.
   - No `dm_ack` is issued; all outputs take their reset values.
   - The following request completes normally.
5. **Fast read** (`DM_SRAM_FASTREAD_EN` defined): load 0x40, load 0x40, store to 0x40, load 0x40.
   - The second load acks at cycle 1 with no `ce_n` activity.
   - The load after the store takes the full 4 cycles and returns the new data.
6. **Back-to-back loads:** `dmce` held continuously across two loads.
   - The second request is accepted one cycle after the first `dm_ack`.
   - There are 5 cycles between the two acks.
